// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_if
// Description : Bundle of the program-ROM read port and the fetch-to-decode
//               handshake. The fetch unit is the master: it drives the ROM
//               address/strobes and the instruction outputs. The slave side
//               is the ROM plus the decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    // Program-ROM read port
    logic [AW-1:0] rom_addr;
    logic          rom_read;
    logic          rom_ena;
    logic [DW-1:0] rom_data;

    // Control from decode / branch logic
    logic          stall;
    logic          jump_en;
    logic [AW-1:0] jump_addr;

    // Instruction presented to decode
    logic          instr_valid;
    logic [DW-1:0] ir;
    logic [DW-1:0] operand;
    logic [AW-1:0] pc_out;
    logic          halted;

    modport master (
        output rom_addr, rom_read, rom_ena,
        input  rom_data,
        input  stall, jump_en, jump_addr,
        output instr_valid, ir, operand, pc_out, halted
    );

    modport slave (
        input  rom_addr, rom_read, rom_ena,
        output rom_data,
        output stall, jump_en, jump_addr,
        input  instr_valid, ir, operand, pc_out, halted
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction-fetch front end. Reads the program ROM one byte
//               per cycle, assembles 1-byte and 2-byte (LDA/STO) instructions
//               and presents one complete instruction per handshake to
//               decode. Supports decode stall and PC redirect (jump_en).
// Options     : IF_HLT_DETECT_EN - when defined, opcode 111 (HLT) is
//               presented and fetch then stops in HALT until jump or reset.
//               When undefined, 111 is an ordinary 1-byte instruction and
//               halted is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter int          AW       = 8,
    parameter int          DW       = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  wire logic     clk,
    input  wire logic     rst,
    instr_fetch_if.master bus
);

    localparam logic [1:0] c_START = 2'd0;
    localparam logic [1:0] c_OP    = 2'd1;
    localparam logic [1:0] c_ARG   = 2'd2;
    localparam logic [1:0] c_HALT  = 2'd3;

    localparam logic [2:0] c_OPC_LDA = 3'b010;
    localparam logic [2:0] c_OPC_STO = 3'b011;

    logic [1:0]    r_state;
    logic [1:0]    w_state_next;
    logic [AW-1:0] r_pc;
    logic [DW-1:0] r_held_op;
    logic [AW-1:0] r_held_addr;
    logic          r_valid;
    logic [DW-1:0] r_ir;
    logic [DW-1:0] r_operand;
    logic [AW-1:0] r_pc_out;

    logic          w_hold;
    logic          w_fetch;
    logic [2:0]    w_opcode;
    logic          w_two_byte;
    logic          w_is_hlt;
    logic          w_op_done;
    logic          w_arg_done;

    // A presented instruction that decode refuses freezes the whole front end.
    assign w_hold     = r_valid && bus.stall;

    // Opcode decode of the byte currently on the ROM bus; only meaningful
    // while w_fetch is high, and every consumer is gated by w_fetch.
    assign w_opcode   = bus.rom_data[DW-1:DW-3];
    assign w_two_byte = (w_opcode == c_OPC_LDA) || (w_opcode == c_OPC_STO);
`ifdef IF_HLT_DETECT_EN
    assign w_is_hlt   = (w_opcode == 3'b111);
`else
    assign w_is_hlt   = 1'b0;
`endif

    // Completion points: a 1-byte opcode in OP, or the operand byte in ARG.
    assign w_op_done  = w_fetch && (r_state == c_OP) && !w_two_byte;
    assign w_arg_done = w_fetch && (r_state == c_ARG);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_START;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a redirect overrides everything, including HALT.
    always_comb begin
        w_state_next = r_state;
        if (bus.jump_en) begin
            w_state_next = c_OP;
        end else begin
            case (r_state)
                c_START: w_state_next = c_OP;
                c_OP: begin
                    if (w_fetch) begin
                        if (w_two_byte) begin
                            w_state_next = c_ARG;
                        end else if (w_is_hlt) begin
                            w_state_next = c_HALT;
                        end else begin
                            w_state_next = c_OP;
                        end
                    end
                end
                c_ARG: begin
                    if (w_fetch) begin
                        w_state_next = c_OP;
                    end
                end
                c_HALT:  w_state_next = c_HALT;
                default: w_state_next = c_START;
            endcase
        end
    end

    // ROM strobes: active only in the byte-fetching states and never while
    // decode is holding the current instruction, so rom_data is sampled only
    // when the ROM is actually driving it.
    always_comb begin
        w_fetch = 1'b0;
        if (!rst && ((r_state == c_OP) || (r_state == c_ARG)) && !w_hold) begin
            w_fetch = 1'b1;
        end
    end

    assign bus.rom_addr = r_pc;
    assign bus.rom_read = w_fetch;
    assign bus.rom_ena  = w_fetch;

    // PC, held opcode and presented-instruction registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc        <= AW'(RESET_PC);
            r_held_op   <= '0;
            r_held_addr <= '0;
            r_valid     <= 1'b0;
            r_ir        <= '0;
            r_operand   <= '0;
            r_pc_out    <= '0;
        end else if (bus.jump_en) begin
            // Redirect: drop whatever is in flight and restart at the target.
            r_pc    <= bus.jump_addr;
            r_valid <= 1'b0;
        end else begin
            if (w_fetch) begin
                r_pc <= r_pc + 1'b1;
            end
            if (w_fetch && (r_state == c_OP) && w_two_byte) begin
                r_held_op   <= bus.rom_data;
                r_held_addr <= r_pc;
            end
            if (w_op_done) begin
                r_ir      <= bus.rom_data;
                r_operand <= '0;
                r_pc_out  <= r_pc;
                r_valid   <= 1'b1;
            end else if (w_arg_done) begin
                r_ir      <= r_held_op;
                r_operand <= bus.rom_data;
                r_pc_out  <= r_held_addr;
                r_valid   <= 1'b1;
            end else if (r_valid && !bus.stall) begin
                r_valid   <= 1'b0;
            end
        end
    end

`ifdef IF_HLT_DETECT_EN
    logic r_halted;

    // Halted flag: set on the edge that presents HLT, cleared by redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_halted <= 1'b0;
        end else if (bus.jump_en) begin
            r_halted <= 1'b0;
        end else if (w_op_done && w_is_hlt) begin
            r_halted <= 1'b1;
        end
    end

    assign bus.halted = r_halted;
`else
    assign bus.halted = 1'b0;
`endif

    assign bus.instr_valid = r_valid;
    assign bus.ir          = r_ir;
    assign bus.operand     = r_operand;
    assign bus.pc_out      = r_pc_out;

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction-fetch front end of the 5-stage pipeline, and the initiator on the program-ROM read interface.
- Drives the ROM address and the read/enable strobes, and samples the 8-bit data returned by the ROM.
- Assembles 1-byte and 2-byte instructions and presents one complete instruction per handshake to the decode stage.
- Supports stall backpressure from decode and a PC redirect.

Parameters:
- AW, 8, ROM address width / PC width.
- DW, 8, ROM data width / instruction byte width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- rom_addr  output  AW  ROM byte address; equals pc.
- rom_read  output  1  ROM read strobe.
- rom_ena  output  1  ROM enable; always equal to rom_read.
- rom_data  input  DW  ROM data; valid combinationally while rom_read && rom_ena, high-Z otherwise.
- stall  input  1  decode cannot accept; holds the current output instruction.
- jump_en  input  1  redirect request.
- jump_addr  input  AW  redirect target.
- instr_valid  output  1  ir, operand and pc_out hold a complete instruction.
- ir  output  DW  opcode byte: [7:5] opcode, [4:0] field.
- operand  output  DW  second byte for 2-byte instructions, else 0.
- pc_out  output  AW  address of the opcode byte of the presented instruction.
- halted  output  1  fetch stopped on HLT (see Optional Feature).

Behaviour:
- Reset (async, immediate):
  - pc = RESET_PC, state = START.
  - instr_valid = 0, ir = 0, operand = 0, pc_out = 0, halted = 0.
  - rom_read = rom_ena = 0 while rst is high.
- States: START, OP, ARG, HALT.
  - START: strobes low. Next edge goes to OP.
  - OP: strobes high, rom_addr = pc. The edge samples the opcode byte and sets pc <= pc+1.
    - If opcode is 010 (LDA) or 011 (STO): hold the byte internally, remember its address, go to ARG. Outputs are unchanged.
    - Otherwise: ir <= byte, operand <= 0, pc_out <= opcode address, instr_valid <= 1, stay in OP.
  - ARG: strobes high, rom_addr = pc. The edge sets ir <= held byte, operand <= rom_data, pc_out <= held address, instr_valid <= 1, pc <= pc+1, and returns to OP.
- Throughput and latency:
  - 1-byte instructions: one per cycle.
  - 2-byte instructions: one per two cycles.
  - instr_valid rises on the edge that samples the last byte of the instruction.
- Backpressure:
  - Accept condition is instr_valid && !stall.
  - In OP or ARG, when instr_valid && stall, the ROM is not accessed: strobes low, and pc, state and outputs are all held.
  - When no instruction completes on an edge where the output is accepted, instr_valid <= 0.
  - The output registers change only when instr_valid is 0 or the output is accepted.
- Redirect:
  - jump_en sampled high: pc <= jump_addr, state <= OP, instr_valid <= 0.
  - Any half-fetched 2-byte instruction is discarded.
  - jump_en has priority over stall and over completing an instruction. It also exits HALT.
- PC arithmetic: modulo 2^AW, so 255 wraps to 0. A 2-byte instruction may straddle the wrap; its opcode is at 255 and its operand at 0.
- rom_data is never sampled while the strobes are low, so a high-Z value is never captured.
- rst asserted mid-instruction aborts immediately to the reset state.

Optional Feature:
- Macro: IF_HLT_DETECT_EN.
- Defined:
  - Opcode 111 is presented as a normal 1-byte instruction.
  - The state then goes to HALT: halted <= 1, strobes low, pc held at the HLT address + 1.
  - HALT is left only by reset or jump_en, and halted clears on exit.
- Not defined:
  - 111 is an ordinary 1-byte instruction and fetch continues.
  - halted is tied to 0.

Test Plan:
- ROM bytes 0x00,0x41,0x03 from address 0, no stall:
  - Cycle after START: ir=0x00, operand=0, pc_out=0, valid.
  - Two cycles later: ir=0x41, operand=0x03, pc_out=1.
  - 2-byte instruction gives a 1-cycle valid gap.
- ROM bytes 0x81,0xA2,0xC1 at addresses 7-9: three back-to-back valid cycles with pc_out=7,8,9 and operand=0.
- Hold stall=1 for 3 cycles while ir=0x41 is valid: outputs stable, rom_read=0, pc stable. On release, the next instruction follows 1 cycle later.
- Assert jump_en with jump_addr=14 while in ARG of the 2-byte instruction at address 10 (bytes 0x61,0x01): that instruction is never presented, and the next valid instruction has pc_out=14.
- Jump to 255 with ROM[255]=0x40 and ROM[0]=0x05: ir=0x40, operand=0x05, pc_out=255, then pc=1.
- IF_HLT_DETECT_EN defined, ROM[19]=0xE0: ir=0xE0 is presented and halted=1 on the next cycle with strobes low. jump_en to 0 clears halted. With the macro undefined, fetch continues at 20.
